// File: rtl/cpu_types_pkg.sv
// Basic CPU word and register-index types shared across the pipeline.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
endpackage

// File: rtl/pipeline_if.sv
// Pipeline latch records plus memory-stage state encoding and helpers.
package pipeline_if;
  import cpu_types_pkg::*;

  typedef struct packed {
    word_t      pc;
    word_t      aluOut;
    word_t      regData2;
    logic       memRen;
    logic       memWen;
    logic [1:0] regDataSel;
    regbits_t   regDest;
    logic       regWen;
  } exec_t;

  typedef struct packed {
    word_t      pc;
    word_t      aluOut;
    word_t      regData2;
    word_t      memData;
    logic [1:0] regDataSel;
    regbits_t   regDest;
    logic       regWen;
  } mem_t;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} memstate_t;

  localparam int TIMEOUT_CYC_DEF = 64;

  function automatic mem_t exec_to_mem(exec_t e, word_t data, logic wen);
    mem_t r;
    r.pc         = e.pc;
    r.aluOut     = e.aluOut;
    r.regData2   = e.regData2;
    r.memData    = data;
    r.regDataSel = e.regDataSel;
    r.regDest    = e.regDest;
    r.regWen     = wen;
    return r;
  endfunction
endpackage

// File: rtl/mem_stage_ctrl.sv
// MIPS memory-stage controller: holds each dcache request until dhit, stalls upstream meanwhile.
// Optional sticky wait-timeout flag enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl
  import cpu_types_pkg::*, pipeline_if::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = 7
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ex_valid,
  input  exec_t ex_in,
  input  logic  flush,
  input  logic  dhit,
  input  word_t dmemload,
  output logic  dmemREN,
  output logic  dmemWEN,
  output word_t dmemaddr,
  output word_t dmemstore,
  output logic  stall,
  output logic  mem_valid,
  output mem_t  mem_out
`ifdef MEM_TIMEOUT_EN
  ,
  output logic  mem_timeout
`endif
);

  memstate_t state, state_next;
  exec_t     req;
  logic      squash;
  logic      take, is_mem, squash_now;
  word_t     load_data;

  assign take       = ex_valid & ~flush;
  assign is_mem     = ex_in.memRen | ex_in.memWen;
  assign squash_now = squash | flush;
  // Write wins over an illegal read+write, so only pure loads return data.
  assign load_data  = (req.memRen & ~req.memWen) ? dmemload : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: if (take && is_mem) state_next = REQ;
      REQ: begin
        stall = ~dhit;
        if (dhit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req       <= '0;
      squash    <= 1'b0;
      mem_valid <= 1'b0;
      mem_out   <= '0;
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      dmemaddr  <= '0;
      dmemstore <= '0;
    end else begin
      case (state)
        IDLE: begin
          squash    <= 1'b0;
          mem_valid <= 1'b0;
          if (take) begin
            if (is_mem) begin
              req       <= ex_in;
              dmemWEN   <= ex_in.memWen;
              dmemREN   <= ex_in.memRen & ~ex_in.memWen;
              dmemaddr  <= {ex_in.aluOut[31:2], 2'b00};
              dmemstore <= ex_in.regData2;
            end else begin
              mem_valid <= 1'b1;
              mem_out   <= exec_to_mem(ex_in, '0, ex_in.regWen);
            end
          end
        end
        REQ: begin
          mem_valid <= 1'b0;
          if (dhit) begin
            // A squashed access still completes on the bus; only the result is killed.
            mem_valid <= ~squash_now;
            mem_out   <= exec_to_mem(req, load_data, req.regWen & ~squash_now);
            dmemREN   <= 1'b0;
            dmemWEN   <= 1'b0;
            squash    <= 1'b0;
          end else if (flush) begin
            squash <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state == IDLE && state_next == REQ) begin
      wait_cnt <= '0;
    end else if (state == REQ && !dhit) begin
      if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt + 1'b1 == CNT_W'(TIMEOUT_CYC)) mem_timeout <= 1'b1;
    end
  end
`endif

endmodule
